// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch front end: holds the PC, selects the next
// fetch address (trap, jump, branch or sequential) and drives a valid/ready fetch request.
module pc_sequencer #(
    parameter int          XLEN       = 32,
    parameter int          STEP       = 4,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
    parameter int          ALIGN_BITS = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            pc_valid,
    output logic            misalign,
    output logic            halted
);

    if (!((STEP == 1) || (STEP == 2) || (STEP == 4) || (STEP == 8) || (STEP == 16))) begin : g_bad_step
        $error("pc_sequencer: STEP must be a power of two in 1..16");
    end
    if (ALIGN_BITS < 0 || ALIGN_BITS >= XLEN) begin : g_bad_align
        $error("pc_sequencer: ALIGN_BITS must be less than XLEN");
    end

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    typedef enum logic [1:0] {
        S_BOOT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_misalign;
    logic            r_halted;

    logic            w_fire;
    logic            w_jb_redirect;
    logic [XLEN-1:0] w_jb_target;
    logic            w_jb_misaligned;
    logic            w_redirect;
    logic [XLEN-1:0] w_run_next_pc;

    assign w_fire          = r_pc_valid & imem_ready;
    assign w_jb_redirect   = jump | branch_taken;
    assign w_jb_target     = jump ? jump_target : branch_target;
    // Misalignment only matters when jump/branch is the winning redirect (not trap).
    assign w_jb_misaligned = !trap && w_jb_redirect && ((w_jb_target & ALIGN_MASK) != '0);
    assign w_redirect      = trap | w_jb_redirect;

    always_comb begin
        w_run_next_pc = r_pc;
        if (trap) begin
            w_run_next_pc = TRAP_VEC;
        end else if (w_jb_redirect) begin
            w_run_next_pc = w_jb_misaligned ? TRAP_VEC : w_jb_target;
        end else if (w_fire && !stall) begin
            w_run_next_pc = pc_plus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VEC;
            r_pc_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                S_BOOT: begin
                    r_state    <= S_RUN;
                    r_pc_valid <= 1'b1;
                end
                S_RUN: begin
                    r_pc       <= w_run_next_pc;
                    r_misalign <= w_jb_misaligned;
                    // Halt once the outstanding fetch is consumed: accepted, or dropped by a redirect.
                    if (halt_req && (w_fire || w_redirect || !r_pc_valid)) begin
                        r_state    <= S_HALTED;
                        r_pc_valid <= 1'b0;
                        r_halted   <= 1'b1;
                    end
                end
                S_HALTED: begin
                    if (trap || resume) begin
                        r_state    <= S_RUN;
                        r_pc_valid <= 1'b1;
                        r_halted   <= 1'b0;
                        if (trap) begin
                            r_pc <= TRAP_VEC;
                        end
                    end
                end
                default: begin
                    r_state    <= S_BOOT;
                    r_pc_valid <= 1'b0;
                    r_halted   <= 1'b0;
                end
            endcase
        end
    end

    assign pc       = r_pc;
    assign pc_plus  = r_pc + XLEN'(STEP);
    assign pc_valid = r_pc_valid;
    assign misalign = r_misalign;
    assign halted   = r_halted;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised successor to the combinational PC+4 adder. Holds the registered program counter and computes the sequential next address with a configurable step. Selects between sequential, branch, jump and trap redirects, and presents the current PC to instruction memory through a valid/ready handshake. Sits between the control unit and instruction memory in the processor front end; supports stall and halt.

Parameters:
XLEN, 32, width of PC and all address ports
STEP, 4, sequential increment in bytes (power of two, 1..16)
RESET_VEC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned redirect
ALIGN_BITS, 2, low target bits that must be zero (log2 of instruction alignment)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  asynchronous, active-low reset
halt_req  in  1  enter HALTED after the current fetch handshake completes
resume  in  1  leave HALTED
stall  in  1  hold PC; suppresses sequential advance only
branch_taken  in  1  branch redirect request
branch_target  in  XLEN  branch destination
jump  in  1  jump redirect request
jump_target  in  XLEN  jump destination
trap  in  1  trap redirect request
imem_ready  in  1  instruction memory accepts pc
pc  out  XLEN  current registered PC
pc_plus  out  XLEN  pc + STEP (combinational, modulo 2^XLEN)
pc_valid  out  1  pc is a valid fetch request
misalign  out  1  one-cycle pulse: a redirect target was misaligned
halted  out  1  high in HALTED state

Behaviour:
- Reset (reset=0, asynchronous): pc=RESET_VEC, state=BOOT, pc_valid=0, misalign=0, halted=0. pc_plus follows pc.
- States: BOOT -> RUN unconditionally on the first clock edge after reset is released (one idle cycle, pc_valid=0). RUN: pc_valid=1. HALTED: pc_valid=0, halted=1.
- Fetch accepted (fire) = pc_valid & imem_ready.
- Next-PC priority in RUN, evaluated every cycle:
  1. trap: pc<=TRAP_VEC.
  2. jump: pc<=jump_target.
  3. branch_taken: pc<=branch_target.
  4. fire & !stall: pc<=pc_plus.
  5. otherwise pc holds.
  Redirects (1-3) take effect regardless of stall and imem_ready; a redirect discards any unaccepted fetch.
- Misalignment: if the selected jump or branch target has any of bits [ALIGN_BITS-1:0] set, load TRAP_VEC instead and pulse misalign=1 for exactly one cycle (registered, visible the cycle pc becomes TRAP_VEC). A trap request never raises misalign.
- Halt: halt_req in RUN moves to HALTED on the edge where fire occurs (PC advanced as normal), or immediately if pc_valid=0. While halt_req is held and no fire occurs, stay in RUN. A redirect in the same cycle as halt_req is applied, then HALTED is entered.
- HALTED: pc frozen and all redirects ignored except trap. A trap loads TRAP_VEC and returns to RUN. resume returns to RUN with pc unchanged. If trap and resume coincide, trap wins; state is RUN either way.
- Wrap-around: pc_plus wraps modulo 2^XLEN (e.g. FFFF_FFFC+4 -> 0000_0000); no flag is raised.
- Reset asserted mid-operation overrides everything immediately.
- STEP must be a power of two, 1..16. ALIGN_BITS must be less than XLEN. Both are checked by an elaboration-time assertion.

Test Plan:
- Reset release, imem_ready=1 constantly -> pc_valid=0 for one cycle, then pc sequence 0,4,8,C; pc_plus=pc+4 each cycle.
- imem_ready=0 for 3 cycles at pc=8 -> pc stays 8, pc_valid=1; with stall=1 and imem_ready=1 -> pc also holds.
- trap, jump=1 (target 0x40) and branch_taken=1 (target 0x80) in one cycle -> next pc=0x100. Jump+branch only -> 0x40. Branch during stall -> 0x80.
- branch_target=0x42 -> next pc=0x100, misalign=1 for one cycle. jump_target=0x44 -> pc=0x44, misalign=0.
- halt_req with imem_ready=1 at pc=0x10 -> pc=0x14, halted=1, pc_valid=0. Jump in HALTED -> ignored. resume -> RUN at 0x14. Trap+resume in HALTED -> pc=0x100, RUN.
- RESET_VEC=32'hFFFF_FFF8 -> pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert reset mid-run -> pc=RESET_VEC asynchronously, then BOOT idle cycle.
